// File: rtl/maple_pkg.sv
// -----------------------------------------------------------------------------
// maple_pkg
// Shared definitions for the Maple bus frame receiver: FSM state encoding,
// start-pattern kinds, done error codes, start pulse counts and the helper
// that ranks error conditions into a single done code.
// -----------------------------------------------------------------------------
package maple_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_DATA     = 2'd2,
        ST_END_WAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_NORMAL    = 2'd0,
        KIND_CRC       = 2'd1,
        KIND_OCCUPANCY = 2'd2
    } kind_t;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_BAD_START    = 3'd1;
    localparam logic [2:0] ERR_PARTIAL_BYTE = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT      = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW     = 3'd4;
    localparam logic [2:0] ERR_TOO_LONG     = 3'd5;

    // SDCKB pulses seen during the start pattern
    localparam logic [3:0] PULSES_NORMAL    = 4'd4;
    localparam logic [3:0] PULSES_CRC       = 4'd6;
    localparam logic [3:0] PULSES_OCCUPANCY = 4'd8;
    localparam logic [3:0] PULSES_BUS_RESET = 4'd14;
    localparam logic [3:0] PULSES_MAX       = 4'd15;

    // Collapse simultaneous error conditions into one code, highest rank first.
    function automatic logic [2:0] err_select(input logic timeout,
                                              input logic partial,
                                              input logic overflow,
                                              input logic too_long);
        logic [2:0] code;
        if (timeout) begin
            code = ERR_TIMEOUT;
        end else if (partial) begin
            code = ERR_PARTIAL_BYTE;
        end else if (overflow) begin
            code = ERR_OVERFLOW;
        end else if (too_long) begin
            code = ERR_TOO_LONG;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/maple_edge_sync.sv
// -----------------------------------------------------------------------------
// maple_edge_sync
// Brings the asynchronous SDCKA/SDCKB pins into the clk domain (2-FF
// synchroniser) and produces registered rise/fall strobes. The level outputs
// are the edge-register copies, so a level read alongside a strobe is the
// post-edge line value. A strobe is high 3 clk after the pin changes.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   sdcka, sdckb        raw bus pins
//   a_lvl, b_lvl        synchronised line levels aligned with the strobes
//   a_fall/a_rise       one-cycle SDCKA edge strobes
//   b_fall/b_rise       one-cycle SDCKB edge strobes
// -----------------------------------------------------------------------------
module maple_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sdcka,
    input  logic sdckb,
    output logic a_lvl,
    output logic b_lvl,
    output logic a_fall,
    output logic a_rise,
    output logic b_fall,
    output logic b_rise
);

    // bit 1 = SDCKA, bit 0 = SDCKB
    logic [1:0] meta_r;
    logic [1:0] sync_r;
    logic [1:0] prev_r;
    logic [1:0] fall_r;
    logic [1:0] rise_r;

    // Synchroniser, edge register and strobe generation. Lines reset to the
    // idle-high level so leaving reset does not produce spurious edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 2'b11;
            sync_r <= 2'b11;
            prev_r <= 2'b11;
            fall_r <= 2'b00;
            rise_r <= 2'b00;
        end else begin
            meta_r <= {sdcka, sdckb};
            sync_r <= meta_r;
            prev_r <= sync_r;
            fall_r <= prev_r & ~sync_r;
            rise_r <= ~prev_r & sync_r;
        end
    end

    assign a_lvl  = prev_r[1];
    assign b_lvl  = prev_r[0];
    assign a_fall = fall_r[1];
    assign b_fall = fall_r[0];
    assign a_rise = rise_r[1];
    assign b_rise = rise_r[0];

endmodule

// File: rtl/maple_frame_rx.sv
// -----------------------------------------------------------------------------
// maple_frame_rx
// Maple bus frame receiver. Classifies the start pattern (NORMAL / CRC /
// OCCUPANCY / bus reset), deserialises data bytes MSB first into a
// first-word-fall-through byte FIFO and emits a one-cycle status pulse per
// frame with byte count, error code and XOR check result.
// Ports:
//   clk, reset                   system clock, synchronous active-high reset
//   sdcka, sdckb                 asynchronous bus pins
//   frame, frame_kind            frame body active / kind of current-last frame
//   out_data, out_sof            FIFO head byte and first-byte-of-frame flag
//   out_valid, out_ready         head handshake; pop on valid & ready
//   fifo_level                   occupied FIFO entries
//   done_valid/len/err/crc_ok    per-frame status pulse
//   bus_reset                    one-cycle pulse on a bus reset pattern
// -----------------------------------------------------------------------------
module maple_frame_rx
    import maple_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int MAX_BYTES      = 1024,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int LEN_W          = $clog2(MAX_BYTES + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sdcka,
    input  logic                            sdckb,
    output logic                            frame,
    output logic [1:0]                      frame_kind,
    output logic [7:0]                      out_data,
    output logic                            out_sof,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            done_valid,
    output logic [LEN_W-1:0]                done_len,
    output logic [2:0]                      done_err,
    output logic                            done_crc_ok,
    output logic                            bus_reset
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic a_lvl_s, b_lvl_s, a_fall_s, a_rise_s, b_fall_s, b_rise_s;

    maple_edge_sync u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .sdcka  (sdcka),
        .sdckb  (sdckb),
        .a_lvl  (a_lvl_s),
        .b_lvl  (b_lvl_s),
        .a_fall (a_fall_s),
        .a_rise (a_rise_s),
        .b_fall (b_fall_s),
        .b_rise (b_rise_s)
    );

    state_t             state_r;
    kind_t              kind_r;
    logic               frame_r;
    logic [3:0]         pulse_cnt_r;
    logic               phase_r;      // 0: expect fall(A), 1: expect fall(B)
    logic               pending_r;
    logic [5:0]         shift_r;
    logic [3:0]         bit_cnt_r;
    logic               commit_r;
    logic [7:0]         commit_byte_r;
    logic [LEN_W-1:0]   len_r;
    logic [7:0]         xor_r;
    logic               ovf_r;
    logic               too_long_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               done_valid_r;
    logic [LEN_W-1:0]   done_len_r;
    logic [2:0]         done_err_r;
    logic               done_crc_ok_r;
    logic               bus_reset_r;

    logic [8:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               any_edge_s;
    logic               pop_s;
    logic               len_full_s;
    logic               push_s;
    logic [3:0]         pulse_next_s;
    logic               tmo_hit_s;
    logic               crc_ok_s;
    logic [8:0]         head_s;

    assign any_edge_s   = a_fall_s | a_rise_s | b_fall_s | b_rise_s;
    assign out_valid    = (count_r != CNT_W'(0));
    assign pop_s        = out_valid & out_ready;
    assign len_full_s   = (len_r == LEN_W'(MAX_BYTES));
    // a pop in the same cycle frees the slot a full FIFO needs
    assign push_s       = commit_r & ~len_full_s &
                          ((count_r != CNT_W'(FIFO_DEPTH)) | pop_s);
    assign pulse_next_s = (b_fall_s && (pulse_cnt_r != PULSES_MAX)) ?
                          pulse_cnt_r + 4'd1 : pulse_cnt_r;
    assign tmo_hit_s    = (state_r != ST_IDLE) & ~any_edge_s &
                          (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
    // the XOR check only means something once a CRC body has started
    assign crc_ok_s     = ((state_r == ST_DATA || state_r == ST_END_WAIT) &&
                           kind_r == KIND_CRC) ? (xor_r == 8'd0) : 1'b1;
    assign head_s       = out_valid ? mem_r[rd_ptr_r] : 9'd0;

    // Frame FSM, deserialiser, byte-commit bookkeeping and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            kind_r        <= KIND_NORMAL;
            frame_r       <= 1'b0;
            pulse_cnt_r   <= 4'd0;
            phase_r       <= 1'b0;
            pending_r     <= 1'b0;
            shift_r       <= 6'd0;
            bit_cnt_r     <= 4'd0;
            commit_r      <= 1'b0;
            commit_byte_r <= 8'd0;
            len_r         <= '0;
            xor_r         <= 8'd0;
            ovf_r         <= 1'b0;
            too_long_r    <= 1'b0;
            tmo_cnt_r     <= '0;
            done_valid_r  <= 1'b0;
            done_len_r    <= '0;
            done_err_r    <= ERR_NONE;
            done_crc_ok_r <= 1'b0;
            bus_reset_r   <= 1'b0;
        end else begin
            done_valid_r <= 1'b0;
            bus_reset_r  <= 1'b0;
            commit_r     <= 1'b0;

            if (any_edge_s || state_r == ST_IDLE) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end

            if (tmo_hit_s) begin
                state_r       <= ST_IDLE;
                frame_r       <= 1'b0;
                done_valid_r  <= 1'b1;
                done_len_r    <= len_r;
                done_err_r    <= err_select(1'b1, 1'b0, ovf_r, too_long_r);
                done_crc_ok_r <= crc_ok_s;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (a_fall_s && b_lvl_s) begin
                            state_r     <= ST_START;
                            pulse_cnt_r <= 4'd0;
                        end
                    end
                    ST_START: begin
                        pulse_cnt_r <= pulse_next_s;
                        if (a_rise_s) begin
                            case (pulse_next_s)
                                PULSES_NORMAL, PULSES_CRC, PULSES_OCCUPANCY: begin
                                    state_r    <= ST_DATA;
                                    frame_r    <= 1'b1;
                                    phase_r    <= 1'b0;
                                    bit_cnt_r  <= 4'd0;
                                    len_r      <= '0;
                                    xor_r      <= 8'd0;
                                    ovf_r      <= 1'b0;
                                    too_long_r <= 1'b0;
                                    if (pulse_next_s == PULSES_NORMAL) begin
                                        kind_r <= KIND_NORMAL;
                                    end else if (pulse_next_s == PULSES_CRC) begin
                                        kind_r <= KIND_CRC;
                                    end else begin
                                        kind_r <= KIND_OCCUPANCY;
                                    end
                                end
                                PULSES_BUS_RESET: begin
                                    state_r     <= ST_IDLE;
                                    bus_reset_r <= 1'b1;
                                end
                                default: begin
                                    state_r       <= ST_IDLE;
                                    done_valid_r  <= 1'b1;
                                    done_len_r    <= '0;
                                    done_err_r    <= ERR_BAD_START;
                                    done_crc_ok_r <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_DATA: begin
                        // fall(A) while fall(B) is due (or both at once) ends the body
                        if (a_fall_s && (phase_r || b_fall_s)) begin
                            state_r <= ST_END_WAIT;
                        end else if (!phase_r && a_fall_s) begin
                            pending_r <= b_lvl_s;
                            phase_r   <= 1'b1;
                        end else if (phase_r && b_fall_s) begin
                            phase_r <= 1'b0;
                            if (bit_cnt_r == 4'd6) begin
                                commit_r      <= 1'b1;
                                commit_byte_r <= {shift_r, pending_r, a_lvl_s};
                                bit_cnt_r     <= 4'd0;
                            end else begin
                                shift_r   <= {shift_r[3:0], pending_r, a_lvl_s};
                                bit_cnt_r <= bit_cnt_r + 4'd2;
                            end
                        end
                    end
                    ST_END_WAIT: begin
                        if (b_rise_s) begin
                            state_r       <= ST_IDLE;
                            frame_r       <= 1'b0;
                            done_valid_r  <= 1'b1;
                            done_len_r    <= len_r;
                            done_err_r    <= err_select(1'b0, bit_cnt_r != 4'd0,
                                                        ovf_r, too_long_r);
                            done_crc_ok_r <= crc_ok_s;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        frame_r <= 1'b0;
                    end
                endcase
            end

            // Commit stage runs one cycle after the last bit pair so that the
            // FIFO full/pop decision and len/XOR use settled values.
            if (commit_r) begin
                xor_r <= xor_r ^ commit_byte_r;
                if (len_full_s) begin
                    too_long_r <= 1'b1;
                end else begin
                    len_r <= len_r + LEN_W'(1);
                    if (!push_s) begin
                        ovf_r <= 1'b1;
                    end
                end
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; entries carry {sof, byte}, sof marks the frame's first byte.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {(len_r == LEN_W'(0)), commit_byte_r};
        end
    end

    assign frame       = frame_r;
    assign frame_kind  = kind_r;
    assign out_data    = head_s[7:0];
    assign out_sof     = head_s[8];
    assign fifo_level  = count_r;
    assign done_valid  = done_valid_r;
    assign done_len    = done_len_r;
    assign done_err    = done_err_r;
    assign done_crc_ok = done_crc_ok_r;
    assign bus_reset   = bus_reset_r;

endmodule
